// File: rtl/atm_ctrl_param.sv
// ATM session controller: card insert, PIN entry with retry limit, amount
// request against a latched balance, dispense, eject, and inactivity timeout.
module atm_ctrl_param #(
    parameter int PIN_DIGITS  = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000,
    parameter int BAL_W       = 16,
    parameter int AMT_W       = 16
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    card,
    input  logic [4*PIN_DIGITS-1:0] pin_ref,
    input  logic [BAL_W-1:0]        bal_in,
    input  logic                    digit_valid,
    input  logic [3:0]              digit,
    input  logic                    a,
    input  logic                    b,
    input  logic                    amt_valid,
    input  logic [AMT_W-1:0]        amt,
    output logic [2:0]              msg,
    output logic                    dispense,
    output logic [AMT_W-1:0]        dispense_amt,
    output logic [BAL_W-1:0]        bal_out,
    output logic                    eject,
    output logic                    retain
);

    localparam int PIN_W = 4 * PIN_DIGITS;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    localparam logic [2:0] MSG_INSERT    = 3'd0;
    localparam logic [2:0] MSG_ENTER_PIN = 3'd1;
    localparam logic [2:0] MSG_WRONG_PIN = 3'd2;
    localparam logic [2:0] MSG_ENTER_AMT = 3'd3;
    localparam logic [2:0] MSG_INSUFF    = 3'd4;
    localparam logic [2:0] MSG_DISPENSE  = 3'd5;
    localparam logic [2:0] MSG_RETAINED  = 3'd6;
    localparam logic [2:0] MSG_TIMEOUT   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PIN      = 3'd1,
        ST_CHECK    = 3'd2,
        ST_MENU     = 3'd3,
        ST_DISPENSE = 3'd4,
        ST_EJECT    = 3'd5,
        ST_RETAIN   = 3'd6
    } state_t;

    state_t             state_q;
    logic [2:0]         msg_q;
    logic               dispense_q;
    logic [AMT_W-1:0]   dispense_amt_q;
    logic [BAL_W-1:0]   bal_q;
    logic               eject_q;
    logic               retain_q;
    logic [TRY_W-1:0]   tries_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PIN_W-1:0]   entry_q;
    logic [PIN_W-1:0]   pin_q;
    logic [AMT_W-1:0]   amt_q;
    logic [TMR_W-1:0]   timer_q;

    logic [TRY_W-1:0]   tries_d;
    logic               timeout_s;

    assign tries_d   = tries_q + TRY_W'(1);
    assign timeout_s = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    // Session sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= ST_IDLE;
            msg_q          <= MSG_INSERT;
            dispense_q     <= 1'b0;
            dispense_amt_q <= '0;
            bal_q          <= '0;
            eject_q        <= 1'b0;
            retain_q       <= 1'b0;
            tries_q        <= '0;
            cnt_q          <= '0;
            entry_q        <= '0;
            pin_q          <= '0;
            amt_q          <= '0;
            timer_q        <= '0;
        end else begin
            dispense_q     <= 1'b0;
            dispense_amt_q <= '0;
            retain_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (card) begin
                        pin_q   <= pin_ref;
                        bal_q   <= bal_in;
                        tries_q <= '0;
                        cnt_q   <= '0;
                        entry_q <= '0;
                        timer_q <= '0;
                        msg_q   <= MSG_ENTER_PIN;
                        state_q <= ST_PIN;
                    end else begin
                        msg_q   <= MSG_INSERT;
                        eject_q <= 1'b0;
                    end
                end
                ST_PIN: begin
                    if (!card) begin
                        msg_q   <= MSG_INSERT;
                        state_q <= ST_IDLE;
                    end else if (b) begin
                        eject_q <= 1'b1;
                        state_q <= ST_EJECT;
                    end else if (digit_valid) begin
                        timer_q <= '0;
                        if (cnt_q < CNT_W'(PIN_DIGITS)) begin
                            entry_q <= (entry_q << 4) | PIN_W'(digit);
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end else begin
                            cnt_q   <= cnt_q;
                        end
                        if (msg_q == MSG_WRONG_PIN) begin
                            msg_q <= MSG_ENTER_PIN;
                        end else begin
                            msg_q <= msg_q;
                        end
                    end else if (a) begin
                        timer_q <= '0;
                        if (cnt_q == CNT_W'(PIN_DIGITS)) begin
                            state_q <= ST_CHECK;
                        end else begin
                            state_q <= ST_PIN;
                        end
                    end else if (amt_valid) begin
                        timer_q <= '0;
                    end else if (timeout_s) begin
                        msg_q   <= MSG_TIMEOUT;
                        eject_q <= 1'b1;
                        state_q <= ST_EJECT;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (!card) begin
                        msg_q   <= MSG_INSERT;
                        state_q <= ST_IDLE;
                    end else if (b) begin
                        eject_q <= 1'b1;
                        state_q <= ST_EJECT;
                    end else if (entry_q == pin_q) begin
                        timer_q <= '0;
                        msg_q   <= MSG_ENTER_AMT;
                        state_q <= ST_MENU;
                    end else if (tries_d == TRY_W'(MAX_TRIES)) begin
                        tries_q  <= tries_d;
                        retain_q <= 1'b1;
                        msg_q    <= MSG_RETAINED;
                        state_q  <= ST_RETAIN;
                    end else begin
                        tries_q <= tries_d;
                        entry_q <= '0;
                        cnt_q   <= '0;
                        timer_q <= '0;
                        msg_q   <= MSG_WRONG_PIN;
                        state_q <= ST_PIN;
                    end
                end
                ST_MENU: begin
                    if (!card) begin
                        msg_q   <= MSG_INSERT;
                        state_q <= ST_IDLE;
                    end else if (b) begin
                        eject_q <= 1'b1;
                        state_q <= ST_EJECT;
                    end else if (amt_valid) begin
                        timer_q <= '0;
                        if (amt == AMT_W'(0)) begin
                            state_q <= ST_MENU;
                        end else if (BAL_W'(amt) > bal_q) begin
                            msg_q <= MSG_INSUFF;
                        end else begin
                            amt_q   <= amt;
                            state_q <= ST_DISPENSE;
                        end
                    end else if (digit_valid || a) begin
                        timer_q <= '0;
                    end else if (timeout_s) begin
                        msg_q   <= MSG_TIMEOUT;
                        eject_q <= 1'b1;
                        state_q <= ST_EJECT;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_DISPENSE: begin
                    // Pulse is issued on leaving, so a card pull here dispenses nothing.
                    if (!card) begin
                        msg_q   <= MSG_INSERT;
                        state_q <= ST_IDLE;
                    end else begin
                        dispense_q     <= 1'b1;
                        dispense_amt_q <= amt_q;
                        bal_q          <= bal_q - BAL_W'(amt_q);
                        msg_q          <= MSG_DISPENSE;
                        eject_q        <= 1'b1;
                        state_q        <= ST_EJECT;
                    end
                end
                ST_EJECT: begin
                    if (!card) begin
                        eject_q <= 1'b0;
                        msg_q   <= MSG_INSERT;
                        state_q <= ST_IDLE;
                    end else begin
                        eject_q <= 1'b1;
                    end
                end
                ST_RETAIN: begin
                    if (!card) begin
                        msg_q   <= MSG_INSERT;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RETAIN;
                    end
                end
                default: begin
                    eject_q <= 1'b0;
                    msg_q   <= MSG_INSERT;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign msg          = msg_q;
    assign dispense     = dispense_q;
    assign dispense_amt = dispense_amt_q;
    assign bal_out      = bal_q;
    assign eject        = eject_q;
    assign retain       = retain_q;

endmodule

// File: tb/tb_atm_ctrl_param.sv
// Bench for atm_ctrl_param: session-level reference model feeds an expected-event
// queue; a monitor pops and compares each display/dispense/retain/eject event.
module tb_atm_ctrl_param;

    localparam int PD = 4;
    localparam int MT = 3;
    localparam int TO = 8;
    localparam int BW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          card = 1'b0;
    logic [15:0]   pin_ref = 16'h0;
    logic [BW-1:0] bal_in = '0;
    logic          digit_valid = 1'b0;
    logic [3:0]    digit = 4'h0;
    logic          a = 1'b0;
    logic          b = 1'b0;
    logic          amt_valid = 1'b0;
    logic [AW-1:0] amt = '0;
    logic [2:0]    msg;
    logic          dispense;
    logic [AW-1:0] dispense_amt;
    logic [BW-1:0] bal_out;
    logic          eject;
    logic          retain;

    atm_ctrl_param #(.PIN_DIGITS(PD), .MAX_TRIES(MT), .TIMEOUT_CYC(TO),
                     .BAL_W(BW), .AMT_W(AW)) dut (
        .clk(clk), .nrst(nrst), .card(card), .pin_ref(pin_ref), .bal_in(bal_in),
        .digit_valid(digit_valid), .digit(digit), .a(a), .b(b),
        .amt_valid(amt_valid), .amt(amt), .msg(msg), .dispense(dispense),
        .dispense_amt(dispense_amt), .bal_out(bal_out), .eject(eject), .retain(retain)
    );

    always #5 clk = ~clk;

    // Event kinds: 0 msg change, 1 dispense pulse, 2 retain pulse, 3 eject rise
    typedef struct {
        int kind;
        int v1;
        int v2;
    } ev_t;
    ev_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Session-level model: 0 idle, 1 PIN entry, 2 menu, 3 ejecting, 4 retained
    int m_state = 0;
    int m_msg = 0;
    int m_bal = 0;
    int m_tries = 0;
    int m_pin[4];
    int m_entry[$];

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push(input int k, input int v1, input int v2);
        ev_t e;
        e.kind = k; e.v1 = v1; e.v2 = v2;
        exp_q.push_back(e);
    endtask

    task automatic exp_msg(input int m);
        if (m != m_msg) push(0, m, 0);
        m_msg = m;
    endtask

    task automatic observe(input int k, input int v1, input int v2);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d val %0d/%0d, expected none", k, v1, v2);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.v1 != v1 || e.v2 != v2) begin
                fails++;
                $display("FAIL event: got kind %0d val %0d/%0d expected kind %0d val %0d/%0d",
                         k, v1, v2, e.kind, e.v1, e.v2);
            end
        end
    endtask

    logic [2:0] prev_msg = 3'd0;
    logic       prev_ej = 1'b0;

    always @(negedge clk) begin
        if (msg != prev_msg) observe(0, int'(msg), 0);
        if (dispense) observe(1, int'(dispense_amt), int'(bal_out));
        if (retain) observe(2, 0, 0);
        if (eject && !prev_ej) observe(3, 0, 0);
        prev_msg <= msg;
        prev_ej  <= eject;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(2, 0)) tick();
    endtask

    task automatic set_pin(input int d0, input int d1, input int d2, input int d3);
        m_pin[0] = d0; m_pin[1] = d1; m_pin[2] = d2; m_pin[3] = d3;
    endtask

    task automatic rand_pin();
        set_pin($urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0));
    endtask

    task automatic insert(input int bal);
        pin_ref = 16'((m_pin[0] << 12) | (m_pin[1] << 8) | (m_pin[2] << 4) | m_pin[3]);
        bal_in  = BW'(bal);
        m_bal   = bal;
        m_tries = 0;
        m_entry.delete();
        m_state = 1;
        exp_msg(1);
        card = 1'b1;
        tick();
        check("bal_latch", int'(bal_out), bal);
    endtask

    task automatic key_digit(input int d);
        if (m_state == 1) begin
            if (m_msg == 2) exp_msg(1);
            if (m_entry.size() < PD) m_entry.push_back(d);
        end
        digit = 4'(d);
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        gap();
    endtask

    function automatic bit entry_ok();
        for (int i = 0; i < PD; i++)
            if (m_entry[i] != m_pin[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic key_a();
        if (m_state == 1 && m_entry.size() == PD) begin
            if (entry_ok()) begin
                exp_msg(3);
                m_state = 2;
            end else begin
                m_tries++;
                if (m_tries == MT) begin
                    exp_msg(6);
                    push(2, 0, 0);
                    m_state = 4;
                end else begin
                    exp_msg(2);
                end
                m_entry.delete();
            end
        end
        a = 1'b1;
        tick();
        a = 1'b0;
        tick();
        tick();
    endtask

    task automatic key_b();
        if (m_state == 1 || m_state == 2) begin
            push(3, 0, 0);
            m_state = 3;
        end
        b = 1'b1;
        tick();
        b = 1'b0;
        tick();
    endtask

    task automatic request(input int x);
        if (m_state == 2 && x != 0) begin
            if (x > m_bal) begin
                exp_msg(4);
            end else begin
                exp_msg(5);
                push(1, x, m_bal - x);
                push(3, 0, 0);
                m_bal = m_bal - x;
                m_state = 3;
            end
        end
        amt = AW'(x);
        amt_valid = 1'b1;
        tick();
        amt_valid = 1'b0;
        amt = '0;
        tick();
        tick();
    endtask

    task automatic enter_pin(input bit good);
        int w[4];
        for (int i = 0; i < PD; i++) w[i] = good ? m_pin[i] : $urandom_range(9, 0);
        if (!good && w[0] == m_pin[0] && w[1] == m_pin[1] && w[2] == m_pin[2] && w[3] == m_pin[3])
            w[3] = (w[3] + 1) % 10;
        for (int i = 0; i < PD; i++) key_digit(w[i]);
        key_a();
    endtask

    task automatic expect_timeout();
        if (m_state == 1 || m_state == 2) begin
            exp_msg(7);
            push(3, 0, 0);
            m_state = 3;
        end
    endtask

    task automatic remove();
        if (m_state == 3) check("eject_hold", int'(eject), 1);
        if (m_state != 0) exp_msg(0);
        m_state = 0;
        card = 1'b0;
        tick();
        tick();
        check("bal_after_pull", int'(bal_out), m_bal);
        check("eject_low", int'(eject), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_msg", int'(msg), 0);
        check("rst_dispense", int'(dispense), 0);
        check("rst_dispense_amt", int'(dispense_amt), 0);
        check("rst_bal", int'(bal_out), 0);
        check("rst_eject", int'(eject), 0);
        check("rst_retain", int'(retain), 0);
    endtask

    task automatic do_reset();
        exp_msg(0);
        m_state = 0;
        m_bal = 0;
        nrst = 1'b0;
        card = 1'b0;
        tick();
        check_reset_outputs();
        nrst = 1'b1;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        #1 nrst = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        nrst = 1'b1;
        tick();

        // Happy path: PIN 1234, balance 500, withdraw 100
        set_pin(1, 2, 3, 4);
        insert(500);
        enter_pin(1'b1);
        request(100);
        repeat (3) tick();
        remove();

        // Three wrong PINs retain the card
        set_pin(1, 2, 3, 4);
        insert(500);
        for (int t = 0; t < MT; t++) begin
            key_digit(1); key_digit(2); key_digit(3); key_digit(5);
            key_a();
        end
        repeat (2) tick();
        remove();

        // Insufficient funds, then exact balance
        set_pin(1, 2, 3, 4);
        insert(500);
        enter_pin(1'b1);
        request(600);
        request(500);
        remove();

        // Timeout with no keys: fires on the 8th edge after PIN entry
        rand_pin();
        insert(300);
        expect_timeout();
        repeat (TO - 1) tick();
        check("timeout_early", int'(msg), 1);
        tick();
        check("timeout_fire", int'(msg), 7);
        tick();
        remove();

        // Digit at cycle 5 restarts the timeout count
        rand_pin();
        insert(300);
        repeat (4) tick();
        m_entry.push_back(1);
        digit = 4'd1;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        expect_timeout();
        repeat (TO - 1) tick();
        check("timeout_restart_early", int'(msg), 1);
        tick();
        check("timeout_restart_fire", int'(msg), 7);
        tick();
        remove();

        // Fifth digit ignored; early 'a' ignored; b+a together cancels
        set_pin(1, 2, 3, 4);
        insert(200);
        key_digit(1); key_digit(2); key_digit(3); key_digit(4); key_digit(9);
        key_a();
        request(50);
        remove();
        set_pin(1, 2, 3, 4);
        insert(200);
        key_digit(1); key_digit(2); key_digit(3);
        key_a();
        key_digit(4);
        key_a();
        remove();
        rand_pin();
        insert(200);
        key_digit(m_pin[0]);
        push(3, 0, 0);
        m_state = 3;
        a = 1'b1;
        b = 1'b1;
        tick();
        a = 1'b0;
        b = 1'b0;
        tick();
        remove();

        // Card pull in MENU holds balance; reset mid-PIN
        rand_pin();
        insert(777);
        enter_pin(1'b1);
        remove();
        rand_pin();
        insert(123);
        key_digit(m_pin[0]);
        key_digit(m_pin[1]);
        do_reset();

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            int kind;
            rand_pin();
            insert($urandom_range(1000, 0));
            gap();
            kind = $urandom_range(5, 0);
            case (kind)
                0, 1: begin
                    int wrong;
                    wrong = $urandom_range(MT - 1, 0);
                    for (int w = 0; w < wrong; w++) enter_pin(1'b0);
                    enter_pin(1'b1);
                    for (int r = 0; r < 3 && m_state == 2; r++)
                        request($urandom_range(m_bal + 200, 0));
                    if (m_state == 2 && $urandom_range(1, 0) == 1) key_b();
                end
                2: for (int w = 0; w < MT; w++) enter_pin(1'b0);
                3: begin
                    key_digit(m_pin[0]);
                    key_b();
                end
                4: begin
                    if ($urandom_range(1, 0) == 1) enter_pin(1'b1);
                    expect_timeout();
                    repeat (TO + 1) tick();
                end
                default: key_digit(m_pin[0]);
            endcase
            gap();
            remove();
        end

        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/atm_ctrl_param.md
Name: atm_ctrl_param

Overview:
- Parametrised next-generation ATM session controller.
- Sequences a card session: card insert, multi-digit PIN entry with retry limit and card retention, amount request against a latched balance, dispense, eject.
- Inactivity timeout in every user-input state.
- Sits between the keypad/card-reader front end and the dispenser/display back end; msg drives the display.

Parameters:
- PIN_DIGITS, 4: PIN length in BCD digits; PIN_W = 4*PIN_DIGITS.
- MAX_TRIES, 3: wrong PINs allowed before the card is retained (>=1).
- TIMEOUT_CYC, 1000: idle cycles in PIN/MENU before forced eject (>=2).
- BAL_W, 16: balance width.
- AMT_W, 16: amount width (AMT_W <= BAL_W).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- card  in  1  level; card present in reader.
- pin_ref  in  PIN_W  stored PIN from card; latched on session start.
- bal_in  in  BAL_W  account balance; latched on session start.
- digit_valid  in  1  one-cycle strobe; keypad digit present.
- digit  in  4  keypad digit (0-9).
- a  in  1  confirm/enter key, one-cycle strobe.
- b  in  1  cancel key, one-cycle strobe.
- amt_valid  in  1  one-cycle strobe; amount request present.
- amt  in  AMT_W  requested amount.
- msg  out  3  display code: 0 INSERT_CARD, 1 ENTER_PIN, 2 WRONG_PIN, 3 ENTER_AMOUNT, 4 INSUFFICIENT, 5 DISPENSING, 6 CARD_RETAINED, 7 TIMEOUT.
- dispense  out  1  one-cycle pulse; dispense dispense_amt.
- dispense_amt  out  AMT_W  amount, valid while dispense=1, else 0.
- bal_out  out  BAL_W  current session balance register.
- eject  out  1  level; eject card.
- retain  out  1  one-cycle pulse; swallow card.

Behaviour:
- All outputs registered. Reset (nrst=0, async):
  - State IDLE; msg=0; dispense=0; dispense_amt=0; bal_out=0; eject=0; retain=0.
  - Try counter, digit counter, entry register and timer all 0.
- States: IDLE, PIN, CHECK, MENU, DISPENSE, EJECT, RETAIN.
- IDLE:
  - card=1 -> latch pin_ref and bal_in (bal_out updates), clear tries -> PIN, msg=1 the following cycle.
- PIN:
  - digit_valid: shift digit into entry register LSB side; count++. Digits beyond PIN_DIGITS are ignored (count saturates).
  - a with count==PIN_DIGITS -> CHECK. a with count<PIN_DIGITS is ignored.
  - First digit after WRONG_PIN returns msg to 1.
- CHECK (exactly 1 cycle):
  - entry==pin_ref -> MENU, msg=3.
  - Mismatch -> tries++. If tries reaches MAX_TRIES -> RETAIN. Otherwise -> PIN, msg=2, entry and count cleared.
- MENU:
  - amt_valid with amt==0: ignored.
  - amt > bal_out: msg=4, stay in MENU, further amt_valid accepted.
  - Otherwise: latch amt -> DISPENSE.
- DISPENSE (1 cycle):
  - dispense=1, dispense_amt=amt, bal_out -= amt (unsigned, never underflows by construction), msg=5.
  - Then -> EJECT.
- EJECT:
  - eject=1 held until card=0, then -> IDLE, eject=0, msg=0.
  - msg keeps its entry value (5 after dispense, 7 on timeout, 1/2/3/4 on cancel).
- RETAIN:
  - retain=1 for the entry cycle only; msg=6.
  - Wait for card=0 -> IDLE, msg=0. eject stays 0.
- Timeout:
  - Timer clears on entering PIN or MENU and on any digit_valid, a, b or amt_valid.
  - Increments otherwise. On reaching TIMEOUT_CYC-1 -> EJECT, msg=7.
- Priority within a cycle, highest first:
  1. card=0 in PIN/CHECK/MENU/DISPENSE aborts -> IDLE. No dispense occurs; bal_out is held.
  2. b (cancel) -> EJECT.
  3. digit_valid (a is ignored in the same cycle).
  4. a.
  5. timeout.
- amt_valid outside MENU, and digit_valid/a outside PIN, are ignored.
- Reset mid-session returns to IDLE immediately. Any dispense pulse in flight is cleared.

Test Plan:
- Reset, card=1, digits 1,2,3,4 with pin_ref=16'h1234, a, amt=100 with bal_in=500 -> msg sequence 1,3,5. dispense pulse exactly 1 cycle with dispense_amt=100. bal_out=400. eject=1 until card=0, then msg=0.
- Wrong PIN 1,2,3,5 + a, three times (MAX_TRIES=3) -> msg=2 after the first and second attempts. Third attempt: retain pulse 1 cycle, msg=6, eject never asserted.
- Correct PIN, amt=600 with bal_in=500 -> msg=4, no dispense. Then amt=500 -> dispense, bal_out=0.
- TIMEOUT_CYC=8, card inserted with no keys -> EJECT, msg=7 on cycle 8 after PIN entry. A digit at cycle 5 restarts the count.
- 5 digits then a -> fifth digit ignored, PIN compares correctly. a after only 3 digits -> stays in PIN. b and a in the same cycle -> EJECT.
- card=0 in MENU, and nrst pulsed mid-PIN -> IDLE, msg=0, all outputs at reset values, bal_out unchanged on card pull.
